// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants and the FSM state type for the pipe_ctrl
//               valid/ready sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int STATE_W     = 2;
  localparam int STAGES_MAX  = 8;
  localparam int STALL_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_valid_cell.sv
`default_nettype none
// ============================================================================
// Module      : pipe_valid_cell
// Description : Occupancy bit for one pipeline stage. Produces the stage's
//               register enable (local ready gated by flush) and the valid
//               value it will hold after the next clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_valid_cell (
  input  logic clk,
  input  logic rst,
  input  logic up_valid,   // occupancy of the stage feeding this one
  input  logic dn_ready,   // ready of the stage this one feeds
  input  logic flush,
  output logic valid,
  output logic en,         // local ready, forced low during flush
  output logic valid_nxt
);

  logic w_ready;

  // A stage can take new data when empty or when its content moves on.
  always_comb begin
    w_ready   = ~valid | dn_ready;
    en        = w_ready & ~flush;
    valid_nxt = flush ? 1'b0 : (en ? up_valid : valid);
  end

  // Occupancy register; enabled stages load upstream occupancy, others hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else begin
      valid <= valid_nxt;
    end
  end

endmodule : pipe_valid_cell
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Valid/ready sequencer for a linear chain of reg_8bit stages.
//               Collapses bubbles, propagates backpressure, supports drain
//               and flush. Optional downstream-stall counter is built when
//               PIPE_CTRL_PERF_EN is defined; otherwise stall_cnt is 0.
//               STAGES must lie in 1..STAGES_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   drain,
  input  logic                   flush,
  output logic [STAGES-1:0]      stage_en,
  output logic [STAGES-1:0]      stage_valid,
  output logic                   busy,
  output logic [STATE_W-1:0]     state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [STAGES-1:0] w_dn_rdy;
  logic [STAGES-1:0] w_valid_nxt;
  logic              w_accept;

  // Downstream ready for each stage, flattened from the ready chain:
  // stage i may advance unless every stage from i+1 to the end is full
  // and the consumer is not taking data.
  always_comb begin : p_dn_rdy
    logic full_above;
    full_above = 1'b1;
    w_dn_rdy   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_dn_rdy[i] = out_ready | ~full_above;
      full_above  = full_above & stage_valid[i];
    end
  end

  // Upstream handshake; stage_en[0] already carries the flush gating.
  always_comb begin
    in_ready  = stage_en[0] & ~drain & (r_state != ST_DRAIN);
    w_accept  = in_valid & in_ready;
    out_valid = stage_valid[STAGES-1] & ~flush;
    busy      = |stage_valid;
    state     = r_state;
  end

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic up_valid;
      if (i == 0) begin : g_head
        assign up_valid = w_accept;
      end else begin : g_link
        assign up_valid = stage_valid[i-1];
      end

      pipe_valid_cell u_cell (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid),
        .dn_ready  (w_dn_rdy[i]),
        .flush     (flush),
        .valid     (stage_valid[i]),
        .en        (stage_en[i]),
        .valid_nxt (w_valid_nxt[i])
      );
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (drain)                        w_state_nxt = ST_DRAIN;
          else if (~|w_valid_nxt && !w_accept) w_state_nxt = ST_IDLE;
        end
        ST_DRAIN: begin
          if (~|stage_valid) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles the last stage waits on the consumer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_stall_cnt <= '0;
    end else if (stage_valid[STAGES-1] && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (STAGES=4). A table of
//               per-cycle vectors plus directed sequences for streaming
//               order, stall-counter saturation, flush and reset mid-drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int S = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, drain, flush;
  logic [S-1:0] stage_en, stage_valid;
  logic         busy;
  logic [1:0]   state;
  logic [7:0]   stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.STAGES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .drain       (drain),
    .flush       (flush),
    .stage_en    (stage_en),
    .stage_valid (stage_valid),
    .busy        (busy),
    .state       (state),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Data chain standing in for the reg_8bit stages, enabled by the DUT.
  logic [7:0] in_data;
  logic [7:0] pdata [S];
  always @(posedge clk) begin
    for (int i = 0; i < S; i++) begin
      if (stage_en[i]) pdata[i] <= (i == 0) ? in_data : pdata[i-1];
    end
  end

  typedef struct {
    logic       iv, ordy, dr, fl;
    logic       ir, ov;
    logic [3:0] en, v;
    logic [1:0] st;
    logic [7:0] sc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, ordy, dr, fl, ir, ov,
                     input logic [3:0] en, v, input logic [1:0] st,
                     input logic [7:0] sc);
    vec_t r;
    r.iv = iv; r.ordy = ordy; r.dr = dr; r.fl = fl;
    r.ir = ir; r.ov = ov; r.en = en; r.v = v; r.st = st; r.sc = sc;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic iv, ordy, dr, fl);
    @(negedge clk);
    in_valid = iv; out_ready = ordy; drain = dr; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 0; out_ready = 1; drain = 0; flush = 0; in_data = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got_v, exp_v;
    int          n_out;
    rst = 1'b1; in_valid = 0; out_ready = 1; drain = 0; flush = 0; in_data = 0;

    //    iv or dr fl  ir ov  en     v      st  sc
    add(0, 1, 0, 0,  1, 0, 4'hF, 4'h0, 2'd0, 8'd0); // reset state
    add(1, 1, 0, 0,  1, 0, 4'hF, 4'h0, 2'd0, 8'd0); // single accept
    add(0, 1, 0, 0,  1, 0, 4'hF, 4'h1, 2'd1, 8'd0);
    add(0, 1, 0, 0,  1, 0, 4'hF, 4'h2, 2'd1, 8'd0);
    add(0, 1, 0, 0,  1, 0, 4'hF, 4'h4, 2'd1, 8'd0);
    add(0, 1, 0, 0,  1, 1, 4'hF, 4'h8, 2'd1, 8'd0); // out 4 cycles later
    add(0, 1, 0, 0,  1, 0, 4'hF, 4'h0, 2'd0, 8'd0); // back to IDLE
    add(1, 0, 0, 0,  1, 0, 4'hF, 4'h0, 2'd0, 8'd0); // fill, consumer stalled
    add(1, 0, 0, 0,  1, 0, 4'hF, 4'h1, 2'd1, 8'd0);
    add(1, 0, 0, 0,  1, 0, 4'hF, 4'h3, 2'd1, 8'd0);
    add(1, 0, 0, 0,  1, 0, 4'hF, 4'h7, 2'd1, 8'd0);
    add(1, 0, 0, 0,  0, 1, 4'h0, 4'hF, 2'd1, 8'd0); // full and stalled
    add(1, 0, 0, 0,  0, 1, 4'h0, 4'hF, 2'd1, 8'd1);
    add(1, 1, 0, 0,  1, 1, 4'hF, 4'hF, 2'd1, 8'd2); // pop + accept together
    add(0, 1, 0, 0,  1, 1, 4'hF, 4'hF, 2'd1, 8'd2);
    add(0, 0, 0, 0,  1, 1, 4'h1, 4'hE, 2'd1, 8'd2); // only the bubble fills
    add(1, 0, 1, 1,  0, 0, 4'h0, 4'hE, 2'd1, 8'd3); // flush with drain
    add(0, 1, 0, 0,  1, 0, 4'hF, 4'h0, 2'd0, 8'd0);
    add(1, 1, 0, 0,  1, 0, 4'hF, 4'h0, 2'd0, 8'd0); // two items then drain
    add(1, 1, 0, 0,  1, 0, 4'hF, 4'h1, 2'd1, 8'd0);
    add(1, 1, 1, 0,  0, 0, 4'hF, 4'h3, 2'd1, 8'd0);
    add(1, 1, 0, 0,  0, 0, 4'hF, 4'h6, 2'd2, 8'd0);
    add(1, 1, 0, 0,  0, 1, 4'hF, 4'hC, 2'd2, 8'd0);
    add(1, 1, 0, 0,  0, 1, 4'hF, 4'h8, 2'd2, 8'd0);
    add(1, 1, 0, 0,  0, 0, 4'hF, 4'h0, 2'd2, 8'd0);
    add(1, 1, 1, 0,  0, 0, 4'hF, 4'h0, 2'd0, 8'd0); // drain in IDLE blocks only
    add(0, 1, 0, 0,  1, 0, 4'hF, 4'h0, 2'd0, 8'd0);

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].iv, tbl[r].ordy, tbl[r].dr, tbl[r].fl);
      got_v = {11'd0, in_ready, out_valid, stage_en, stage_valid, state, busy, stall_cnt};
      exp_v = {11'd0, tbl[r].ir, tbl[r].ov, tbl[r].en, tbl[r].v, tbl[r].st,
               |tbl[r].v, (PERF ? tbl[r].sc : 8'd0)};
      chk($sformatf("vec[%0d]{ir,ov,en,v,st,busy,sc}", r), got_v, exp_v);
    end

    // Stream of 10 items: consecutive, in order, 4-cycle latency.
    n_out = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      in_valid = (n < 10); in_data = 8'(16 + n); out_ready = 1; drain = 0; flush = 0;
      #1;
      if (n < 10) chk($sformatf("stream_in_ready[%0d]", n), {31'd0, in_ready}, 32'd1);
      if (out_valid) begin
        chk($sformatf("stream_out[%0d]{cycle,data}", n_out),
            {16'd0, 8'(n), pdata[S-1]}, {16'd0, 8'(n_out + 4), 8'(16 + n_out)});
        n_out++;
      end
    end
    chk("stream_count", 32'(n_out), 32'd10);

    // Fill with consumer stalled, then count stall cycles to saturation.
    do_reset();
    for (int n = 0; n < 4; n++) drive(1, 0, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      drive(0, 0, 0, 0);
      if (k == 2) chk("full_stall{ir,en,v}", {23'd0, in_ready, stage_en, stage_valid}, {23'd0, 1'b0, 4'h0, 4'hF});
      if (k == 2 || k == 3 || k == 4 || k == 256 || k == 257 || k == 300)
        chk($sformatf("stall_cnt[k=%0d]", k), {24'd0, stall_cnt},
            {24'd0, (PERF ? 8'((k - 1 > 255) ? 255 : k - 1) : 8'd0)});
    end
    drive(0, 0, 0, 1);
    chk("flush_cycle{ov,ir,en}", {26'd0, out_valid, in_ready, stage_en}, 32'd0);
    drive(0, 1, 0, 0);
    chk("after_flush{v,st,sc}", {18'd0, stage_valid, state, stall_cnt}, 32'd0);

    // Reset while draining returns to the reset state.
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(0, 1, 1, 0);
    drive(0, 1, 0, 0);
    chk("mid_drain{st,v}", {26'd0, state, stage_valid}, {26'd0, 2'd2, 4'h6});
    rst = 1'b1;
    drive(0, 1, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_drain{v,st,sc,ov,busy,en,ir}",
        {14'd0, stage_valid, state, stall_cnt, out_valid, busy, stage_en, in_ready},
        {14'd0, 4'h0, 2'd0, 8'd0, 1'b0, 1'b0, 4'hF, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_ctrl
`default_nettype wire
